ram_sdp_sync_read: RTL and testbench
====================================

RAM_SDP_SYNC_READ -- requirements
Module: ram_sdp_sync_read

Interface
REQ-001 Parameter DATA_WIDTH, default 8, SHALL set the word width in bits (legal range 1..64).
REQ-002 Parameter ADDR_WIDTH, default 4, SHALL set the address width; DEPTH = 2**ADDR_WIDTH words (default 16).
REQ-003 Parameter RDW_MODE, default 0, SHALL select same-address read-during-write: 0 = read-old, 1 = write-through.
REQ-004 Parameter OUT_REG, default 0, SHALL add one output pipeline stage when 1.
REQ-005 Port clk, input, 1, SHALL be the single clock; all logic runs on its rising edge.
REQ-006 Port rst, input, 1, SHALL be the asynchronous, active-high reset.
REQ-007 Port clr, input, 1, SHALL request a full-memory clear sweep when pulsed high.
REQ-008 Port wr_en, input, 1, SHALL qualify a write, active high.
REQ-009 Port wr_addr, input, ADDR_WIDTH, SHALL be the write address.
REQ-010 Port wr_data, input, DATA_WIDTH, SHALL be the write data.
REQ-011 Port rd_en, input, 1, SHALL qualify a read, active high.
REQ-012 Port rd_addr, input, ADDR_WIDTH, SHALL be the read address.
REQ-013 Port rd_data, output, DATA_WIDTH, SHALL be the registered read data.
REQ-014 Port rd_valid, output, 1, SHALL pulse high for one cycle when rd_data carries a new read result.
REQ-015 Port init_busy, output, 1, SHALL be high while the clear sweep runs; accesses are ignored.

Function
REQ-016 The block SHALL contain a DEPTH x DATA_WIDTH array with independent write and read ports.
REQ-017 Control SHALL be a two-state FSM, INIT and READY; rst forces INIT with sweep counter 0.
REQ-018 In INIT, each cycle SHALL write 0 to address counter and increment it; at counter DEPTH-1, the write completes and the next state is READY.
REQ-019 The INIT sweep SHALL take exactly DEPTH cycles after rst deassertion; init_busy SHALL fall on the edge entering READY.
REQ-020 In INIT, wr_en and rd_en SHALL be ignored: no array write, no rd_valid.
REQ-021 In READY, wr_en=1 SHALL write wr_data to wr_addr on that edge.
REQ-022 In READY, rd_en=1 at edge N SHALL present ram[rd_addr] on rd_data with rd_valid=1 after edge N+1 (OUT_REG=0) or edge N+2 (OUT_REG=1).
REQ-023 Back-to-back reads SHALL be accepted every cycle; throughput one read per clock.
REQ-024 When no read completes, rd_data SHALL hold its last value and rd_valid SHALL be 0.
REQ-025 Same-address read and write in one cycle SHALL return the pre-write word if RDW_MODE=0, wr_data if RDW_MODE=1.
REQ-026 Writes and reads to different addresses in one cycle SHALL both complete without interaction.
REQ-027 clr=1 in READY SHALL return to INIT with counter 0 and drop any write in that cycle; reads already in the pipeline SHALL still complete.
REQ-028 clr=1 during INIT SHALL be ignored; the sweep is not restarted.
REQ-029 Addresses SHALL be full-range; no out-of-range condition exists and no wrap logic beyond ADDR_WIDTH truncation is needed.

Reset
REQ-030 rst high SHALL immediately force: state INIT, counter 0, init_busy 1, rd_valid 0, rd_data 0, output pipeline cleared.
REQ-031 rst asserted mid-sweep or mid-read SHALL abandon the operation; a full DEPTH-cycle sweep SHALL follow deassertion.
REQ-032 Array contents SHALL NOT be reset directly; zero contents are guaranteed only through the sweep.

Verification
REQ-033 Defaults, rst pulse then idle -> init_busy high exactly 16 cycles after deassertion; read all 16 addresses -> each rd_data 0x00, rd_valid one cycle after rd_en.
REQ-034 Write 0xA5 to addr 3, then read addr 3 -> rd_data 0xA5, rd_valid 1 one cycle later (two with OUT_REG=1).
REQ-035 Addr 7 holds 0x11; write 0x22 to addr 7 while reading addr 7 -> 0x11 with RDW_MODE=0, 0x22 with RDW_MODE=1; following read -> 0x22.
REQ-036 Write 0x5A to addr 2, pulse clr with wr_en=1 (addr 4, 0xFF) -> init_busy 16 cycles; afterwards addr 2 and addr 4 read 0x00.
REQ-037 Assert rst at sweep cycle 8 with rd_en=1 -> rd_valid 0 and rd_data 0 immediately; full 16-cycle sweep after release.
REQ-038 DATA_WIDTH=32, ADDR_WIDTH=6, streaming reads of 64 addresses every cycle after random writes -> 64 consecutive rd_valid pulses, data matching the reference model.

Source files
------------

// File: rtl/ram_sdp_sync_read.sv
// Simple dual-port RAM with synchronous read, power-up/clear zeroing sweep,
// selectable read-during-write behaviour and optional output pipeline stage.
module ram_sdp_sync_read #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int RDW_MODE   = 0,
    parameter int OUT_REG    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  init_busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_init_busy;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  r_rd_valid1;
    logic [DATA_WIDTH-1:0] r_rd_data1;

    logic                  w_ready;
    logic                  w_mem_we;
    logic [ADDR_WIDTH-1:0] w_mem_waddr;
    logic [DATA_WIDTH-1:0] w_mem_wdata;
    logic                  w_rd_fire;
    logic [DATA_WIDTH-1:0] w_rd_word;

    // The sweep owns the write port in INIT; clr in READY drops the user write.
    assign w_ready     = (r_state == ST_READY);
    assign w_mem_we    = w_ready ? (wr_en && !clr) : 1'b1;
    assign w_mem_waddr = w_ready ? wr_addr : r_cnt;
    assign w_mem_wdata = w_ready ? wr_data : '0;
    assign w_rd_fire   = w_ready && rd_en;

    assign w_rd_word = (RDW_MODE == 1 && w_ready && w_mem_we && (w_mem_waddr == rd_addr))
                     ? w_mem_wdata : r_mem[rd_addr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; this is also what makes read-old behaviour fall out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_init_busy <= 1'b1;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + ADDR_WIDTH'(1);
                    if (r_cnt == '1) begin
                        r_state     <= ST_READY;
                        r_cnt       <= '0;
                        r_init_busy <= 1'b0;
                    end
                end
                ST_READY: begin
                    if (clr) begin
                        r_state     <= ST_INIT;
                        r_cnt       <= '0;
                        r_init_busy <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_INIT;
                    r_cnt       <= '0;
                    r_init_busy <= 1'b1;
                end
            endcase
        end
    end

    // NOTE: the array has no reset so it maps onto RAM macros; zeroing is the sweep's job.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid1 <= 1'b0;
            r_rd_data1  <= '0;
        end else begin
            r_rd_valid1 <= w_rd_fire;
            if (w_rd_fire) begin
                r_rd_data1 <= w_rd_word;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  r_rd_valid2;
            logic [DATA_WIDTH-1:0] r_rd_data2;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_rd_valid2 <= 1'b0;
                    r_rd_data2  <= '0;
                end else begin
                    r_rd_valid2 <= r_rd_valid1;
                    if (r_rd_valid1) begin
                        r_rd_data2 <= r_rd_data1;
                    end
                end
            end

            assign rd_valid = r_rd_valid2;
            assign rd_data  = r_rd_data2;
        end else begin : g_no_out_reg
            assign rd_valid = r_rd_valid1;
            assign rd_data  = r_rd_data1;
        end
    endgenerate

    assign init_busy = r_init_busy;

endmodule

// File: tb/tb_ram_sdp_sync_read.sv
// Scoreboard bench: a default instance (read-old, no output register) and a
// 32x64 instance (write-through, output register) share clock and reset.
module tb_ram_sdp_sync_read;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       clr0 = 0, wr_en0 = 0, rd_en0 = 0;
    logic [3:0] wr_addr0 = 0, rd_addr0 = 0;
    logic [7:0] wr_data0 = 0;
    logic [7:0] rd_data0;
    logic       rd_valid0, init_busy0;

    logic        clr1 = 0, wr_en1 = 0, rd_en1 = 0;
    logic [5:0]  wr_addr1 = 0, rd_addr1 = 0;
    logic [31:0] wr_data1 = 0;
    logic [31:0] rd_data1;
    logic        rd_valid1, init_busy1;

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [31:0] model1 [64];

    ram_sdp_sync_read dut0 (
        .clk(clk), .rst(rst), .clr(clr0),
        .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
        .rd_en(rd_en0), .rd_addr(rd_addr0),
        .rd_data(rd_data0), .rd_valid(rd_valid0), .init_busy(init_busy0)
    );

    ram_sdp_sync_read #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .RDW_MODE(1), .OUT_REG(1)) dut1 (
        .clk(clk), .rst(rst), .clr(clr1),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .rd_en(rd_en1), .rd_addr(rd_addr1),
        .rd_data(rd_data1), .rd_valid(rd_valid1), .init_busy(init_busy1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void push0(input logic [31:0] d);
        q0.push_back('{data: d, cyc: cyc});
    endfunction

    function automatic void push1(input logic [31:0] d);
        q1.push_back('{data: d, cyc: cyc});
    endfunction

    // Monitors: pop on every rd_valid, checking data and latency in cycles.
    always @(negedge clk) begin
        exp_t e;
        if (rd_valid0) begin
            if (q0.size() == 0) begin
                check("unexpected_valid0", 1, 0);
            end else begin
                e = q0.pop_front();
                check("rd_data0", 64'(rd_data0), 64'(e.data));
                check("latency0", 64'(cyc - e.cyc), 1);
            end
        end
        if (rd_valid1) begin
            if (q1.size() == 0) begin
                check("unexpected_valid1", 1, 0);
            end else begin
                e = q1.pop_front();
                check("rd_data1", 64'(rd_data1), 64'(e.data));
                check("latency1", 64'(cyc - e.cyc), 2);
            end
        end
    end

    // Counts cycles until both sweeps finish; drives ignored traffic into dut0 meanwhile.
    task automatic count_sweeps(output int n0, output int n1);
        int n = 0;
        n0 = 0;
        n1 = 0;
        rd_en0 = 1; rd_addr0 = 4'd0;
        wr_en0 = 1; wr_addr0 = 4'd0; wr_data0 = 8'hEE;
        while ((init_busy0 || init_busy1) && n < 200) begin
            tick();
            n++;
            if (n0 == 0 && !init_busy0) begin
                n0 = n;
                rd_en0 = 0;
                wr_en0 = 0;
            end
            if (n1 == 0 && !init_busy1) n1 = n;
        end
        rd_en0 = 0;
        wr_en0 = 0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 20) begin
            tick();
            n++;
        end
        check("drain_pending", 64'(q0.size() + q1.size()), 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int n0, n1, n;

        // Reset state
        repeat (3) tick();
        check("rst_valid0", rd_valid0, 0);
        check("rst_data0", rd_data0, 0);
        check("rst_busy0", init_busy0, 1);
        check("rst_valid1", rd_valid1, 0);
        check("rst_data1", rd_data1, 0);
        check("rst_busy1", init_busy1, 1);
        rst = 0;

        // Power-up sweep lengths: DEPTH cycles each
        count_sweeps(n0, n1);
        check("sweep_len0", n0, 16);
        check("sweep_len1", n1, 64);

        // All 16 words read back zero, back-to-back
        for (int a = 0; a < 16; a++) begin
            rd_en0 = 1; rd_addr0 = 4'(a); push0(32'h00);
            tick();
        end
        rd_en0 = 0;
        drain();

        // Simple write then read
        wr_en0 = 1; wr_addr0 = 4'd3; wr_data0 = 8'hA5; tick();
        wr_en0 = 0; rd_en0 = 1; rd_addr0 = 4'd3; push0(32'hA5); tick();
        rd_en0 = 0;

        // Same-address read during write: read-old on dut0
        wr_en0 = 1; wr_addr0 = 4'd7; wr_data0 = 8'h11; tick();
        wr_data0 = 8'h22; rd_en0 = 1; rd_addr0 = 4'd7; push0(32'h11); tick();
        wr_en0 = 0; push0(32'h22); tick();

        // Different addresses in the same cycle
        wr_en0 = 1; wr_addr0 = 4'd8; wr_data0 = 8'h33; rd_addr0 = 4'd3; push0(32'hA5); tick();
        wr_en0 = 0; rd_addr0 = 4'd8; push0(32'h33); tick();
        rd_en0 = 0;
        drain();
        check("hold_data0", rd_data0, 8'h33);
        check("hold_valid0", rd_valid0, 0);

        // clr drops the same-cycle write; clr during sweep is ignored
        wr_en0 = 1; wr_addr0 = 4'd2; wr_data0 = 8'h5A; tick();
        clr0 = 1; wr_addr0 = 4'd4; wr_data0 = 8'hFF; tick();
        clr0 = 0; wr_en0 = 0;
        check("clr_busy0", init_busy0, 1);
        n = 0;
        while (init_busy0 && n < 100) begin
            clr0 = (n == 5);
            tick();
            n++;
        end
        clr0 = 0;
        check("clr_sweep_len0", n, 16);
        rd_en0 = 1;
        rd_addr0 = 4'd2; push0(32'h00); tick();
        rd_addr0 = 4'd4; push0(32'h00); tick();
        rd_addr0 = 4'd7; push0(32'h00); tick();
        rd_en0 = 0;
        drain();

        // Reset in the middle of a sweep with rd_en high
        wr_en0 = 1; wr_addr0 = 4'd3; wr_data0 = 8'hA5; tick();
        wr_en0 = 0; rd_en0 = 1; rd_addr0 = 4'd3; push0(32'hA5); tick();
        rd_en0 = 0;
        drain();
        clr0 = 1; tick();
        clr0 = 0; rd_en0 = 1; rd_addr0 = 4'd3;
        repeat (7) tick();
        check("sweep_hold_data0", rd_data0, 8'hA5);
        rst = 1;
        #1;
        check("midrst_valid0", rd_valid0, 0);
        check("midrst_data0", rd_data0, 0);
        check("midrst_busy0", init_busy0, 1);
        rd_en0 = 0;
        repeat (2) tick();
        rst = 0;
        count_sweeps(n0, n1);
        check("resweep_len0", n0, 16);
        check("resweep_len1", n1, 64);
        rd_en0 = 1; rd_addr0 = 4'd3; push0(32'h00); tick();
        rd_en0 = 0;
        drain();

        // Wide instance: write-through on same-address access, 2-cycle latency
        wr_en1 = 1; wr_addr1 = 6'd7; wr_data1 = 32'h11; tick();
        wr_data1 = 32'h22; rd_en1 = 1; rd_addr1 = 6'd7; push1(32'h22); tick();
        wr_en1 = 0; push1(32'h22); tick();
        rd_en1 = 0;
        drain();

        // Random fill, then stream 64 reads every cycle
        for (int a = 0; a < 64; a++) begin
            model1[a] = $urandom;
            wr_en1 = 1; wr_addr1 = 6'(a); wr_data1 = model1[a];
            tick();
        end
        wr_en1 = 0;
        for (int a = 0; a < 64; a++) begin
            rd_en1 = 1; rd_addr1 = 6'(63 - a); push1(model1[63 - a]);
            tick();
        end
        rd_en1 = 0;
        drain();
        check("final_hold_valid1", rd_valid1, 0);
        check("final_hold_data1", rd_data1, 64'(model1[0]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
